// File: rtl/din_debounce_sync.sv
// din_debounce_sync: synchronises a raw async level into clk,
// debounces it with a qualify counter and emits rise/fall pulses.
module din_debounce_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 4,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    input  logic en,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    generate
        if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_params
            $error("din_debounce_sync: SYNC_STAGES>=2 and DB_CYCLES>=1");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: shifts every cycle, independent of en.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Qualify FSM: a new level of s must survive DB_CYCLES enabled cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (s != dout_q && en) begin
                    if (DB_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (s == dout_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            dout_d  = s;
            cnt_d   = '0;
            state_d = ST_STABLE;
            rise_d  = s;
            fall_d  = ~s;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_QUALIFY);

endmodule

// File: tb/tb_din_debounce_sync.sv
// tb_din_debounce_sync: scoreboard bench for two configurations of
// din_debounce_sync (defaults, and SYNC_STAGES=3 / DB_CYCLES=1).
module tb_din_debounce_sync;

    localparam int SS0 = 2;
    localparam int DB0 = 4;
    localparam int SS1 = 3;
    localparam int DB1 = 1;

    logic clk = 1'b0;
    logic resetn;
    logic din;
    logic en;
    logic dout0, rise0, fall0, busy0;
    logic dout1, rise1, fall1, busy1;

    always #5 clk = ~clk;

    din_debounce_sync #(
        .SYNC_STAGES(SS0),
        .DB_CYCLES  (DB0),
        .RESET_VAL  (1'b0)
    ) u_dut0 (
        .clk   (clk),
        .resetn(resetn),
        .din   (din),
        .en    (en),
        .dout  (dout0),
        .rise  (rise0),
        .fall  (fall0),
        .busy  (busy0)
    );

    din_debounce_sync #(
        .SYNC_STAGES(SS1),
        .DB_CYCLES  (DB1),
        .RESET_VAL  (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .resetn(resetn),
        .din   (din),
        .en    (en),
        .dout  (dout1),
        .rise  (rise1),
        .fall  (fall1),
        .busy  (busy1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: s is din delayed by the stage count; a change is
    // accepted once s has differed from dout for db enabled samples.
    int   ss[2] = '{SS0, SS1};
    int   db[2] = '{DB0, DB1};
    logic hist[2][8];
    logic m_dout[2];
    logic m_rise[2];
    logic m_fall[2];
    int   streak[2];

    logic [7:0] expq[$];

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) hist[i][k] = 1'b0;
            m_dout[i] = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            streak[i] = 0;
        end
    endtask

    task automatic m_step();
        logic sv;
        for (int i = 0; i < 2; i++) begin
            sv = hist[i][ss[i]-1];
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (sv == m_dout[i]) begin
                streak[i] = 0;
            end else if (en) begin
                streak[i]++;
                if (streak[i] == db[i]) begin
                    m_dout[i] = sv;
                    m_rise[i] = sv;
                    m_fall[i] = !sv;
                    streak[i] = 0;
                end
            end
            for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = din;
        end
    endtask

    // One clock: model the edge, drive new inputs, queue the expectation.
    task automatic cyc(input logic d, input logic e, input logic r);
        @(posedge clk);
        if (!resetn) m_reset();
        else m_step();
        #1;
        din    = d;
        en     = e;
        resetn = !r;
        if (r) m_reset();
        expq.push_back({m_dout[0], m_rise[0], m_fall[0], streak[0] != 0,
                        m_dout[1], m_rise[1], m_fall[1], streak[1] != 0});
    endtask

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s {dout,rise,fall,busy} got=%b want=%b t=%0t",
                     nm, got, want, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] ex;
        if (expq.size() > 0) begin
            ex = expq.pop_front();
            chk("dut0", {dout0, rise0, fall0, busy0}, ex[7:4]);
            chk("dut1", {dout1, rise1, fall1, busy1}, ex[3:0]);
        end
    end

    initial begin
        int   n;
        int   len;
        int   mode;
        int   tries;
        logic d;
        logic e;

        resetn = 1'b0;
        din    = 1'b1;
        en     = 1'b1;
        m_reset();

        // Reset held with din high, then release.
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b1, 1'b0);

        // Clean edges.
        repeat (20) cyc(1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b1, 1'b0);
        repeat (20) cyc(1'b0, 1'b1, 1'b0);

        // Short pulses around the qualify length.
        for (int g = 2; g <= 6; g++) begin
            repeat (g) cyc(1'b1, 1'b1, 1'b0);
            repeat (15) cyc(1'b0, 1'b1, 1'b0);
        end

        // Enable on every third cycle only.
        for (int k = 0; k < 40; k++) cyc(1'b1, (k % 3) == 0, 1'b0);
        for (int k = 0; k < 40; k++) cyc(1'b0, (k % 3) == 0, 1'b0);

        // Asynchronous reset while the default instance is qualifying.
        tries = 0;
        while (streak[0] != 2 && tries < 20) begin
            cyc(1'b1, 1'b1, 1'b0);
            tries++;
        end
        total++;
        if (streak[0] != 2) begin
            bad++;
            $display("FAIL mid_qualify_reach got=%0d want=2", streak[0]);
        end
        cyc(1'b1, 1'b1, 1'b1);
        repeat (12) cyc(1'b1, 1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b1, 1'b0);

        // Randomised segments with mixed enable patterns and rare resets.
        n = 0;
        while (n < 3000) begin
            d    = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 9);
            mode = $urandom_range(0, 2);
            for (int k = 0; k < len; k++) begin
                case (mode)
                    0:       e = 1'b1;
                    1:       e = (n % 3) == 0;
                    default: e = 1'($urandom_range(0, 1));
                endcase
                cyc(d, e, $urandom_range(0, 299) == 0);
                n++;
            end
        end

        repeat (3) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL queue_drain got=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
